// File: rtl/usb_pkg.sv
// Shared USB device-controller types: frontend line states, device states,
// and the rule for how an applied SET_ADDRESS moves the device state.
package usb_pkg;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } usb_linestate_t;

  typedef enum logic [1:0] {
    POWERED    = 2'd0,
    DEFAULT    = 2'd1,
    ADDRESS    = 2'd2,
    CONFIGURED = 2'd3
  } usb_dev_state_t;

  // Width of the idle-J counter; saturates at all ones.
  localparam int JCNT_W = 18;

  // Device state after a pending SET_ADDRESS is committed at its status stage.
  // CONFIGURED keeps its state; only the address changes.
  function automatic usb_dev_state_t addr_apply_state(input usb_dev_state_t s,
                                                      input logic [6:0]     a);
    case (s)
      DEFAULT: return (a != 7'd0) ? ADDRESS : DEFAULT;
      ADDRESS: return (a == 7'd0) ? DEFAULT : ADDRESS;
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/usb_line_mon.sv
// Line-timing monitor: qualifies bus reset from consecutive SE0 cycles and
// idle (suspend) from consecutive J cycles. Both outputs are registered.
module usb_line_mon
  import usb_pkg::*;
#(
  parameter int RESET_CYC = 120,
  parameter int SUSP_CYC  = 144000
) (
  input  logic           clk,
  input  logic           rst,
  input  usb_linestate_t linestate,
  output logic           bus_reset,
  output logic           idle_timeout
);

  localparam int SE0_W = $clog2(RESET_CYC + 1);

  logic [SE0_W-1:0]  r_se0_cnt;
  logic [JCNT_W-1:0] r_j_cnt;
  logic              r_bus_reset;
  logic              r_idle;
  logic              w_se0;
  logic              w_j;

  assign w_se0        = (linestate == SE0);
  assign w_j          = (linestate == J);
  assign bus_reset    = r_bus_reset;
  assign idle_timeout = r_idle;

  // SE0 run length; the counter parks at RESET_CYC so the pulse fires once per SE0 run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_se0_cnt   <= '0;
      r_bus_reset <= 1'b0;
    end else if (w_se0) begin
      r_bus_reset <= (r_se0_cnt == SE0_W'(RESET_CYC - 1));
      if (r_se0_cnt != SE0_W'(RESET_CYC))
        r_se0_cnt <= r_se0_cnt + SE0_W'(1);
    end else begin
      r_se0_cnt   <= '0;
      r_bus_reset <= 1'b0;
    end
  end

  // Idle-J run length; the level drops the cycle after any non-J line state (K, SE0, SE1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_j_cnt <= '0;
      r_idle  <= 1'b0;
    end else if (w_j) begin
      r_idle <= (r_j_cnt >= JCNT_W'(SUSP_CYC - 1));
      if (r_j_cnt != '1)
        r_j_cnt <= r_j_cnt + JCNT_W'(1);
    end else begin
      r_j_cnt <= '0;
      r_idle  <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_dev_ctrl.sv
// USB device state controller: tracks POWERED/DEFAULT/ADDRESS/CONFIGURED,
// the device address (committed at the status stage) and configuration value.
// Suspend is an orthogonal flag supplied by the line monitor.
module usb_dev_ctrl
  import usb_pkg::*;
#(
  parameter int RESET_CYC = 120,
  parameter int SUSP_CYC  = 144000
) (
  input  logic           clk,
  input  logic           rst,
  input  usb_linestate_t linestate,
  input  logic           addr_set_req,
  input  logic [6:0]     addr_val,
  input  logic           cfg_set_req,
  input  logic [7:0]     cfg_val,
  input  logic           status_ack,
  output logic [6:0]     dev_addr,
  output logic [7:0]     dev_cfg,
  output usb_dev_state_t dev_state,
  output logic           suspend,
  output logic           bus_reset
);

  usb_dev_state_t r_state;
  logic [6:0]     r_addr;
  logic [7:0]     r_cfg;
  logic [6:0]     r_pend_addr;
  logic           r_pend_vld;
  logic           w_bus_reset;
  logic           w_idle_timeout;
  logic           w_sie_en;
  logic           w_apply_addr;

  usb_line_mon #(
    .RESET_CYC (RESET_CYC),
    .SUSP_CYC  (SUSP_CYC)
  ) u_line_mon (
    .clk          (clk),
    .rst          (rst),
    .linestate    (linestate),
    .bus_reset    (w_bus_reset),
    .idle_timeout (w_idle_timeout)
  );

  // SIE requests are meaningless until the host has reset the device.
  assign w_sie_en     = (r_state != POWERED);
  // A new SET_ADDRESS in the same cycle as a status ACK only replaces the pending value.
  assign w_apply_addr = w_sie_en && status_ack && r_pend_vld && !addr_set_req;

  assign dev_addr  = r_addr;
  assign dev_cfg   = r_cfg;
  assign dev_state = r_state;
  assign suspend   = w_idle_timeout;
  assign bus_reset = w_bus_reset;

  // Device state machine; bus reset overrides any same-cycle SIE request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= POWERED;
      r_addr      <= '0;
      r_cfg       <= '0;
      r_pend_addr <= '0;
      r_pend_vld  <= 1'b0;
    end else if (w_bus_reset) begin
      r_state    <= DEFAULT;
      r_addr     <= '0;
      r_cfg      <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_sie_en) begin
      if (addr_set_req) begin
        r_pend_addr <= addr_val;
        r_pend_vld  <= 1'b1;
      end else if (w_apply_addr) begin
        r_addr     <= r_pend_addr;
        r_pend_vld <= 1'b0;
        r_state    <= addr_apply_state(r_state, r_pend_addr);
      end
      // A committed address change takes the state this cycle; a colliding config request is dropped.
      if (cfg_set_req && !w_apply_addr) begin
        case (r_state)
          ADDRESS: begin
            if (cfg_val != 8'd0) begin
              r_state <= CONFIGURED;
              r_cfg   <= cfg_val;
            end
          end
          CONFIGURED: begin
            if (cfg_val == 8'd0) begin
              r_state <= ADDRESS;
              r_cfg   <= '0;
            end else begin
              r_cfg <= cfg_val;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_dev_ctrl.sv
// Directed bench for usb_dev_ctrl with a short suspend threshold.
module tb_usb_dev_ctrl;
  import usb_pkg::*;

  logic           clk;
  logic           rst;
  usb_linestate_t linestate;
  logic           addr_set_req;
  logic [6:0]     addr_val;
  logic           cfg_set_req;
  logic [7:0]     cfg_val;
  logic           status_ack;
  logic [6:0]     dev_addr;
  logic [7:0]     dev_cfg;
  usb_dev_state_t dev_state;
  logic           suspend;
  logic           bus_reset;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [6:0] a;
    logic [7:0] c;
    logic       s;
    logic       br;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   br_seen  = 0;
  int   br_base  = 0;

  usb_dev_ctrl #(
    .RESET_CYC (120),
    .SUSP_CYC  (1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .linestate    (linestate),
    .addr_set_req (addr_set_req),
    .addr_val     (addr_val),
    .cfg_set_req  (cfg_set_req),
    .cfg_val      (cfg_val),
    .status_ack   (status_ack),
    .dev_addr     (dev_addr),
    .dev_cfg      (dev_cfg),
    .dev_state    (dev_state),
    .suspend      (suspend),
    .bus_reset    (bus_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count bus_reset pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_reset === 1'b1) br_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input usb_dev_state_t st, input logic [6:0] a,
                            input logic [7:0] c, input logic s, input logic br);
    exp_t e;
    e.tag = tag; e.st = st; e.a = a; e.c = c; e.s = s; e.br = br;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".state"},   32'(dev_state), 32'(e.st));
      chk({e.tag, ".addr"},    32'(dev_addr),  32'(e.a));
      chk({e.tag, ".cfg"},     32'(dev_cfg),   32'(e.c));
      chk({e.tag, ".suspend"}, 32'(suspend),   32'(e.s));
      chk({e.tag, ".bus_rst"}, 32'(bus_reset), 32'(e.br));
    end
  endtask

  task automatic set_addr(input logic [6:0] v);
    addr_set_req = 1'b1; addr_val = v;
    cyc(1);
    addr_set_req = 1'b0;
  endtask

  task automatic ack();
    status_ack = 1'b1;
    cyc(1);
    status_ack = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] v);
    cfg_set_req = 1'b1; cfg_val = v;
    cyc(1);
    cfg_set_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; linestate = J;
    addr_set_req = 1'b0; addr_val = '0;
    cfg_set_req = 1'b0; cfg_val = '0; status_ack = 1'b0;
    cyc(3);
    expect_out("reset", POWERED, 7'h00, 8'h00, 1'b0, 1'b0); drain();

    // SIE traffic before any bus reset is ignored
    rst = 1'b1;
    set_addr(7'h11); ack(); set_cfg(8'h01);
    expect_out("powered_ignore", POWERED, 7'h00, 8'h00, 1'b0, 1'b0); drain();

    // 119 SE0 cycles do not qualify
    br_base = br_seen;
    linestate = SE0; cyc(119);
    linestate = J;   cyc(5);
    expect_out("se0_119", POWERED, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    chk("se0_119_pulses", 32'(br_seen - br_base), 32'd0);

    // 120 SE0 cycles qualify exactly one pulse
    br_base = br_seen;
    linestate = SE0; cyc(119);
    expect_out("se0_pre", POWERED, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    cyc(1);
    expect_out("br_pulse", POWERED, 7'h00, 8'h00, 1'b0, 1'b1); drain();
    cyc(1);
    expect_out("br_default", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    cyc(20);
    linestate = J; cyc(1);
    chk("br_single_pulse", 32'(br_seen - br_base), 32'd1);

    // Address is held pending until the status stage
    set_addr(7'h2A); cyc(4);
    expect_out("addr_pending", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    ack();
    expect_out("addr_applied", ADDRESS, 7'h2A, 8'h00, 1'b0, 1'b0); drain();
    ack();
    expect_out("ack_no_pend", ADDRESS, 7'h2A, 8'h00, 1'b0, 1'b0); drain();

    // Configuration transitions
    set_cfg(8'h01);
    expect_out("cfg_1", CONFIGURED, 7'h2A, 8'h01, 1'b0, 1'b0); drain();
    set_cfg(8'h05);
    expect_out("cfg_5", CONFIGURED, 7'h2A, 8'h05, 1'b0, 1'b0); drain();
    set_cfg(8'h00);
    expect_out("cfg_0", ADDRESS, 7'h2A, 8'h00, 1'b0, 1'b0); drain();
    set_addr(7'h00); ack();
    expect_out("addr_zero", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    set_cfg(8'h03);
    expect_out("cfg_in_default", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    set_addr(7'h33); ack(); set_cfg(8'h02);
    expect_out("reconfig", CONFIGURED, 7'h33, 8'h02, 1'b0, 1'b0); drain();

    // Same-cycle SET_ADDRESS and status ACK only latches
    addr_set_req = 1'b1; addr_val = 7'h44; status_ack = 1'b1;
    cyc(1);
    addr_set_req = 1'b0; status_ack = 1'b0;
    expect_out("same_cyc_latch", CONFIGURED, 7'h33, 8'h02, 1'b0, 1'b0); drain();
    ack();
    expect_out("cfg_addr_update", CONFIGURED, 7'h44, 8'h02, 1'b0, 1'b0); drain();

    // Suspend after 1000 idle-J cycles, resume on one K
    linestate = K; cyc(1);
    linestate = J; cyc(999);
    expect_out("pre_suspend", CONFIGURED, 7'h44, 8'h02, 1'b0, 1'b0); drain();
    cyc(1);
    expect_out("suspend", CONFIGURED, 7'h44, 8'h02, 1'b1, 1'b0); drain();
    set_cfg(8'h07);
    expect_out("sie_in_suspend", CONFIGURED, 7'h44, 8'h07, 1'b1, 1'b0); drain();
    linestate = K; cyc(1);
    expect_out("resume", CONFIGURED, 7'h44, 8'h07, 1'b0, 1'b0); drain();
    linestate = J;

    // Bus reset beats a same-cycle status ACK with pending address
    set_addr(7'h05);
    linestate = SE0; cyc(120);
    expect_out("br_vs_ack_pulse", CONFIGURED, 7'h44, 8'h07, 1'b0, 1'b1); drain();
    ack();
    expect_out("br_priority", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    linestate = J; cyc(2);
    ack();
    expect_out("pend_cleared", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0); drain();

    // Asynchronous reset mid-SE0 and mid-pending
    set_addr(7'h12);
    linestate = SE0; cyc(60);
    rst = 1'b0; #1;
    expect_out("async_reset", POWERED, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    cyc(2);
    rst = 1'b1;
    br_base = br_seen;
    cyc(119);
    expect_out("post_rst_119", POWERED, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    cyc(1);
    expect_out("post_rst_pulse", POWERED, 7'h00, 8'h00, 1'b0, 1'b1); drain();
    cyc(1);
    expect_out("post_rst_default", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0); drain();
    linestate = J; cyc(2);
    chk("post_rst_pulses", 32'(br_seen - br_base), 32'd1);
    ack();
    expect_out("post_rst_no_pend", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
